// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: boot, load-use stall and branch-flush control for the 5-stage pipeline.
// Define SEQ_INT_EN to build in the interrupt-entry sequence (drain, push PC, load vector).
module pipeline_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int RESET_VEC = 0,
    parameter int INT_VEC   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic [2:0]        ifid_rs,
    input  logic [2:0]        ifid_rd,
    input  logic              ifid_uses_rs,
    input  logic              ifid_uses_rd,
    input  logic              idex_mem_read,
    input  logic [2:0]        idex_rd,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       fetch_pc,
    input  logic [ADDR_W-1:0] sp,
    input  logic [15:0]       mem_rdata,
    output logic              pc_write,
    output logic              pc_load,
    output logic [31:0]       pc_load_val,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              seq_mem_req,
    output logic              seq_mem_we,
    output logic [ADDR_W-1:0] seq_mem_addr,
    output logic [15:0]       seq_mem_wdata,
    output logic              sp_dec,
    output logic              int_ack,
    output logic              busy
);

    localparam logic [2:0] S_BOOT_LO = 3'd0;
    localparam logic [2:0] S_BOOT_HI = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
`ifdef SEQ_INT_EN
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_PUSH_HI = 3'd4;
    localparam logic [2:0] S_PUSH_LO = 3'd5;
    localparam logic [2:0] S_VEC_LO  = 3'd6;
    localparam logic [2:0] S_VEC_HI  = 3'd7;

    localparam logic [ADDR_W-1:0] INT_LO = ADDR_W'(INT_VEC);
    localparam logic [ADDR_W-1:0] INT_HI = ADDR_W'(INT_VEC + 1);
`endif
    localparam logic [ADDR_W-1:0] RST_LO = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] RST_HI = ADDR_W'(RESET_VEC + 1);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [15:0] lo_half;
    logic        latch_lo;
    logic        hazard;

    assign hazard = idex_mem_read &
                    ((ifid_uses_rs & (ifid_rs == idex_rd)) |
                     (ifid_uses_rd & (ifid_rd == idex_rd)));

`ifdef SEQ_INT_EN
    logic [31:0] saved_pc;
    logic [2:0]  drain_cnt;
    logic        int_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saved_pc  <= '0;
            drain_cnt <= '0;
        end else if (int_start) begin
            saved_pc  <= fetch_pc;
            drain_cnt <= 3'(DRAIN_CYC - 1);
        end else if (state == S_DRAIN && drain_cnt != 3'd0) begin
            drain_cnt <= drain_cnt - 3'd1;
        end
    end
`else
    logic unused_int;
    assign unused_int = ^{int_req, fetch_pc, sp, INT_VEC[0], DRAIN_CYC[0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_BOOT_LO;
            lo_half <= '0;
        end else begin
            state <= state_next;
            if (latch_lo) lo_half <= mem_rdata;
        end
    end

    always_comb begin
        state_next    = state;
        latch_lo      = 1'b0;
        pc_write      = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = '0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        seq_mem_req   = 1'b0;
        seq_mem_we    = 1'b0;
        seq_mem_addr  = '0;
        seq_mem_wdata = '0;
        sp_dec        = 1'b0;
        int_ack       = 1'b0;
        busy          = 1'b1;
`ifdef SEQ_INT_EN
        int_start     = 1'b0;
`endif
        case (state)
            S_BOOT_LO: begin
                seq_mem_req  = 1'b1;
                seq_mem_addr = RST_LO;
                latch_lo     = 1'b1;
                state_next   = S_BOOT_HI;
            end
            S_BOOT_HI: begin
                seq_mem_req  = 1'b1;
                seq_mem_addr = RST_HI;
                pc_load      = 1'b1;
                pc_load_val  = {mem_rdata, lo_half};
                state_next   = S_RUN;
            end
            S_RUN: begin
                busy = 1'b0;
                if (branch_taken) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    pc_load     = 1'b1;
                    pc_load_val = branch_target;
                end else if (hazard) begin
                    ifid_flush  = 1'b0;
`ifdef SEQ_INT_EN
                end else if (int_req) begin
                    idex_bubble = 1'b0;
                    int_start   = 1'b1;
                    state_next  = S_DRAIN;
`endif
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_bubble = 1'b0;
                end
            end
`ifdef SEQ_INT_EN
            S_DRAIN: begin
                if (drain_cnt == 3'd0) state_next = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                seq_mem_req   = 1'b1;
                seq_mem_we    = 1'b1;
                seq_mem_addr  = sp;
                seq_mem_wdata = saved_pc[31:16];
                sp_dec        = 1'b1;
                state_next    = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                seq_mem_req   = 1'b1;
                seq_mem_we    = 1'b1;
                seq_mem_addr  = sp;
                seq_mem_wdata = saved_pc[15:0];
                sp_dec        = 1'b1;
                state_next    = S_VEC_LO;
            end
            S_VEC_LO: begin
                seq_mem_req  = 1'b1;
                seq_mem_addr = INT_LO;
                latch_lo     = 1'b1;
                state_next   = S_VEC_HI;
            end
            S_VEC_HI: begin
                seq_mem_req  = 1'b1;
                seq_mem_addr = INT_HI;
                pc_load      = 1'b1;
                pc_load_val  = {mem_rdata, lo_half};
                int_ack      = 1'b1;
                state_next   = S_RUN;
            end
`endif
            default: state_next = S_BOOT_LO;
        endcase
        // While reset is held, BOOT_LO must not claim the memory port yet.
        if (!rst) begin
            seq_mem_req  = 1'b0;
            seq_mem_addr = '0;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: boot, hazards, branches, randomized RUN traffic,
// and the interrupt sequence (or its absence) depending on SEQ_INT_EN.
module tb_pipeline_sequencer;

    localparam int ADDR_W = 16;
    // {pc_write, ifid_write, ifid_flush, idex_bubble, busy, pc_load, seq_mem_req, sp_dec, int_ack}
    localparam logic [8:0] CTL_RESET = 9'b001110000;

    logic              clk;
    logic              rst;
    logic              int_req;
    logic [2:0]        ifid_rs;
    logic [2:0]        ifid_rd;
    logic              ifid_uses_rs;
    logic              ifid_uses_rd;
    logic              idex_mem_read;
    logic [2:0]        idex_rd;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       fetch_pc;
    logic [ADDR_W-1:0] sp;
    logic [15:0]       mem_rdata;
    logic              pc_write;
    logic              pc_load;
    logic [31:0]       pc_load_val;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              seq_mem_req;
    logic              seq_mem_we;
    logic [ADDR_W-1:0] seq_mem_addr;
    logic [15:0]       seq_mem_wdata;
    logic              sp_dec;
    logic              int_ack;
    logic              busy;

    logic [15:0] mem [0:65535];
    logic [31:0] pc_m;
    int          checks;
    int          errors;
    int          acks;

    pipeline_sequencer #(
        .ADDR_W(ADDR_W), .RESET_VEC(0), .INT_VEC(2), .DRAIN_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .int_req(int_req),
        .ifid_rs(ifid_rs), .ifid_rd(ifid_rd),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rd(ifid_uses_rd),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .fetch_pc(fetch_pc), .sp(sp), .mem_rdata(mem_rdata),
        .pc_write(pc_write), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .seq_mem_req(seq_mem_req), .seq_mem_we(seq_mem_we), .seq_mem_addr(seq_mem_addr),
        .seq_mem_wdata(seq_mem_wdata), .sp_dec(sp_dec), .int_ack(int_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[seq_mem_addr];

    function automatic logic [8:0] ctl();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, busy,
                pc_load, seq_mem_req, sp_dec, int_ack};
    endfunction

    task automatic set_idle();
        int_req       = 1'b0;
        ifid_rs       = 3'd0;
        ifid_rd       = 3'd0;
        ifid_uses_rs  = 1'b0;
        ifid_uses_rd  = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd       = 3'd0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        fetch_pc      = 32'd0;
    endtask

    // Advance one clock; the bench's memory, SP and PC react to what the DUT asked for.
    task automatic cycle();
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic              dec;
        logic              ld;
        logic              pw;
        logic [31:0]       lv;
        w   = seq_mem_req & seq_mem_we;
        a   = seq_mem_addr;
        d   = seq_mem_wdata;
        dec = sp_dec;
        ld  = pc_load;
        lv  = pc_load_val;
        pw  = pc_write;
        if (int_ack) acks++;
        @(posedge clk);
        #1;
        if (w) mem[a] = d;
        if (dec) sp = sp - ADDR_W'(1);
        if (ld) pc_m = lv;
        else if (pw) pc_m = pc_m + 32'd4;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ctl() !== CTL_RESET) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl(), CTL_RESET);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl() !== CTL_RESET) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", ctl(), CTL_RESET);
        end
        @(negedge clk);
    endtask

    task automatic test_boot();
        rst = 1'b1;
        #1;
        checks++;
        if (seq_mem_req !== 1'b1 || seq_mem_we !== 1'b0 || seq_mem_addr !== 16'h0000 ||
            busy !== 1'b1 || pc_load !== 1'b0) begin
            errors++;
            $display("FAIL boot_lo got req=%b we=%b addr=%h busy=%b ld=%b exp 1 0 0000 1 0",
                     seq_mem_req, seq_mem_we, seq_mem_addr, busy, pc_load);
        end
        cycle();
        #1;
        checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 32'h0000_0010 || seq_mem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL boot_hi got ld=%b val=%h addr=%h exp 1 00000010 0001",
                     pc_load, pc_load_val, seq_mem_addr);
        end
        cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || seq_mem_req !== 1'b0 || pc_m !== 32'h0000_0010) begin
            errors++;
            $display("FAIL boot_run got busy=%b req=%b pc=%h exp 0 0 00000010",
                     busy, seq_mem_req, pc_m);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] pc0;
        pc0 = pc_m;
        idex_mem_read = 1'b1;
        idex_rd       = 3'd3;
        ifid_rs       = 3'd3;
        ifid_uses_rs  = 1'b1;
        ifid_rd       = 3'd5;
        ifid_uses_rd  = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_write, idex_bubble, ifid_flush, pc_load} !== 5'b00100) begin
            errors++;
            $display("FAIL load_use_stall got pw=%b iw=%b bb=%b fl=%b ld=%b exp 0 0 1 0 0",
                     pc_write, ifid_write, idex_bubble, ifid_flush, pc_load);
        end
        cycle();
        idex_mem_read = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110 || pc_m !== pc0) begin
            errors++;
            $display("FAIL load_use_release got pw=%b iw=%b bb=%b pc=%h exp 1 1 0 %h",
                     pc_write, ifid_write, idex_bubble, pc_m, pc0);
        end
        cycle();
        set_idle();
    endtask

    task automatic test_branch_hazard();
        idex_mem_read = 1'b1;
        idex_rd       = 3'd3;
        ifid_rs       = 3'd3;
        ifid_uses_rs  = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        #1;
        checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 32'h40 || ifid_flush !== 1'b1 ||
            idex_bubble !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL branch_hazard got ld=%b val=%h fl=%b bb=%b pw=%b exp 1 00000040 1 1 1",
                     pc_load, pc_load_val, ifid_flush, idex_bubble, pc_write);
        end
        cycle();
        set_idle();
        #1;
        checks++;
        if (pc_m !== 32'h40) begin
            errors++;
            $display("FAIL branch_pc got=%h exp=00000040", pc_m);
        end
    endtask

    task automatic test_random();
        logic [2:0] reads [$];
        logic       haz;
        logic [4:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            idex_mem_read = 1'($urandom_range(0, 1));
            idex_rd       = 3'($urandom_range(0, 7));
            ifid_rs       = ($urandom_range(0, 1) != 0) ? idex_rd : 3'($urandom_range(0, 7));
            ifid_rd       = ($urandom_range(0, 1) != 0) ? idex_rd : 3'($urandom_range(0, 7));
            ifid_uses_rs  = 1'($urandom_range(0, 1));
            ifid_uses_rd  = 1'($urandom_range(0, 1));
            fetch_pc      = $urandom;
            reads.delete();
            if (ifid_uses_rs) reads.push_back(ifid_rs);
            if (ifid_uses_rd) reads.push_back(ifid_rd);
            haz = 1'b0;
            if (idex_mem_read)
                foreach (reads[k]) if (reads[k] == idex_rd) haz = 1'b1;
            // {pc_write, ifid_write, ifid_flush, idex_bubble, pc_load}
            if (branch_taken) exp_v = 5'b11111;
            else if (haz)     exp_v = 5'b00010;
            else              exp_v = 5'b11000;
            #1;
            checks++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, pc_load} !== exp_v ||
                seq_mem_req !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] got=%b req=%b busy=%b exp=%b req=0 busy=0",
                         i, {pc_write, ifid_write, ifid_flush, idex_bubble, pc_load},
                         seq_mem_req, busy, exp_v);
            end
            if (branch_taken) begin
                checks++;
                if (pc_load_val !== branch_target) begin
                    errors++;
                    $display("FAIL random_target[%0d] got=%h exp=%h", i, pc_load_val, branch_target);
                end
            end
            cycle();
        end
        set_idle();
    endtask

`ifdef SEQ_INT_EN
    task automatic test_interrupt();
        int acks0;
        acks0 = acks;
        mem[2] = 16'hBEEF;
        mem[3] = 16'hCAFE;
        sp            = 16'h0FFF;
        fetch_pc      = 32'h1234_5678;
        int_req       = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        #1;
        checks++;
        if (pc_load !== 1'b1 || busy !== 1'b0 || seq_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL int_deferred got ld=%b busy=%b req=%b exp 1 0 0", pc_load, busy, seq_mem_req);
        end
        cycle();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pc_write !== 1'b0 || ifid_flush !== 1'b1 || pc_load !== 1'b0) begin
            errors++;
            $display("FAIL int_entry got busy=%b pw=%b fl=%b ld=%b exp 0 0 1 0",
                     busy, pc_write, ifid_flush, pc_load);
        end
        cycle();
        fetch_pc     = 32'hDEAD_0000;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl() !== 9'b001110000) begin
                errors++;
                $display("FAIL drain[%0d] got=%b exp=001110000", i, ctl());
            end
            cycle();
        end
        branch_taken = 1'b0;
        #1;
        checks++;
        if (seq_mem_req !== 1'b1 || seq_mem_we !== 1'b1 || seq_mem_addr !== 16'h0FFF ||
            seq_mem_wdata !== 16'h1234 || sp_dec !== 1'b1) begin
            errors++;
            $display("FAIL push_hi got req=%b we=%b addr=%h wd=%h dec=%b exp 1 1 0fff 1234 1",
                     seq_mem_req, seq_mem_we, seq_mem_addr, seq_mem_wdata, sp_dec);
        end
        cycle();
        #1;
        checks++;
        if (seq_mem_we !== 1'b1 || seq_mem_addr !== 16'h0FFE ||
            seq_mem_wdata !== 16'h5678 || sp_dec !== 1'b1) begin
            errors++;
            $display("FAIL push_lo got we=%b addr=%h wd=%h dec=%b exp 1 0ffe 5678 1",
                     seq_mem_we, seq_mem_addr, seq_mem_wdata, sp_dec);
        end
        cycle();
        #1;
        checks++;
        if (seq_mem_req !== 1'b1 || seq_mem_we !== 1'b0 || seq_mem_addr !== 16'h0002 || sp_dec !== 1'b0) begin
            errors++;
            $display("FAIL vec_lo got req=%b we=%b addr=%h dec=%b exp 1 0 0002 0",
                     seq_mem_req, seq_mem_we, seq_mem_addr, sp_dec);
        end
        cycle();
        #1;
        checks++;
        if (seq_mem_addr !== 16'h0003 || pc_load !== 1'b1 || pc_load_val !== 32'hCAFE_BEEF ||
            int_ack !== 1'b1) begin
            errors++;
            $display("FAIL vec_hi got addr=%h ld=%b val=%h ack=%b exp 0003 1 cafebeef 1",
                     seq_mem_addr, pc_load, pc_load_val, int_ack);
        end
        cycle();
        int_req = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || int_ack !== 1'b0 || mem[16'h0FFF] !== 16'h1234 ||
            mem[16'h0FFE] !== 16'h5678 || sp !== 16'h0FFD || pc_m !== 32'hCAFE_BEEF ||
            acks - acks0 !== 1) begin
            errors++;
            $display("FAIL int_done got busy=%b ack=%b m0fff=%h m0ffe=%h sp=%h pc=%h acks=%0d exp 0 0 1234 5678 0ffd cafebeef 1",
                     busy, int_ack, mem[16'h0FFF], mem[16'h0FFE], sp, pc_m, acks - acks0);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        sp       = 16'h0FFF;
        fetch_pc = 32'hAAAA_5555;
        int_req  = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        checks++;
        if (seq_mem_we !== 1'b1 || seq_mem_addr !== 16'h0FFE || seq_mem_wdata !== 16'h5555) begin
            errors++;
            $display("FAIL mid_push_lo got we=%b addr=%h wd=%h exp 1 0ffe 5555",
                     seq_mem_we, seq_mem_addr, seq_mem_wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl() !== CTL_RESET) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", ctl(), CTL_RESET);
        end
        int_req = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (seq_mem_req !== 1'b1 || seq_mem_addr !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reboot_lo got req=%b addr=%h busy=%b exp 1 0000 1", seq_mem_req, seq_mem_addr, busy);
        end
        cycle();
        cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || pc_m !== 32'h10) begin
            errors++;
            $display("FAIL reboot_run got busy=%b pc=%h exp 0 00000010", busy, pc_m);
        end
    endtask
`else
    task automatic test_int_ignored();
        int_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++;
            if (busy !== 1'b0 || int_ack !== 1'b0 || sp_dec !== 1'b0 || pc_write !== 1'b1) begin
                errors++;
                $display("FAIL int_ignored[%0d] got busy=%b ack=%b dec=%b pw=%b exp 0 0 0 1",
                         i, busy, int_ack, sp_dec, pc_write);
            end
            cycle();
        end
        int_req = 1'b0;
    endtask
`endif

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        sp     = 16'h0FFF;
        pc_m   = 32'd0;
        checks = 0;
        errors = 0;
        acks   = 0;
        set_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0010;
        mem[1] = 16'h0000;

        test_reset();
        test_boot();
        test_load_use();
        test_branch_hazard();
        test_random();
`ifdef SEQ_INT_EN
        test_interrupt();
        test_reset_mid();
`else
        test_int_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
